// File: rtl/feature_row_streamer.sv
// Captures a flat H*K feature map on done_i and streams it one channel per
// valid/ready beat, applying optional ReLU and 1x2 max-pool on the way out.
module feature_row_streamer #(
    parameter int H          = 24,
    parameter int K          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RELU       = 1,
    parameter int POOL       = 0,
    localparam int OW        = (POOL != 0) ? H / 2 : H,
    localparam int CH_W      = $clog2(K + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [H*K*DATA_WIDTH-1:0]     feat_i,
    input  logic                          done_i,
    output logic [OW*DATA_WIDTH-1:0]      data_o,
    output logic [CH_W-1:0]               ch_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          last_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overrun_o,
    output logic [1:0]                    state_o
);
    localparam int ROW_W = H * DATA_WIDTH;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(K - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [H*K*DATA_WIDTH-1:0] buf_q;
    logic                      load;
    logic [ROW_W-1:0]          row;
    logic signed [DATA_WIDTH-1:0] elem [H];

    // rst_n is active-high despite its name; a reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (load) buf_q <= feat_i;
        end
    end

    // A beat transfers on a rising edge where valid_o & ready_i; until then
    // valid_o, ch_o and data_o hold steady. ready_i is ignored outside STREAM.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        load      = 1'b0;
        valid_o   = 1'b0;
        last_o    = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        overrun_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_i) begin
                    load    = 1'b1;
                    ch_d    = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                valid_o   = 1'b1;
                busy_o    = 1'b1;
                last_o    = (ch_q == LAST_CH);
                overrun_o = done_i;
                if (ready_i) begin
                    if (ch_q == LAST_CH) state_d = DONE;
                    else                 ch_d    = ch_q + 1'b1;
                end
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                if (done_i) begin
                    load    = 1'b1;
                    ch_d    = '0;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_o    = ch_q;
    assign state_o = state_q;
    assign row     = buf_q[int'(ch_q) * ROW_W +: ROW_W];

    for (genvar n = 0; n < H; n++) begin : g_elem
        logic signed [DATA_WIDTH-1:0] raw;
        assign raw     = row[n*DATA_WIDTH +: DATA_WIDTH];
        assign elem[n] = (RELU != 0 && raw < 0) ? '0 : raw;
    end

    if (POOL != 0) begin : g_pool
        // Ties keep the even element.
        for (genvar n = 0; n < OW; n++) begin : g_out
            assign data_o[n*DATA_WIDTH +: DATA_WIDTH] =
                (elem[2*n+1] > elem[2*n]) ? elem[2*n+1] : elem[2*n];
        end
    end else begin : g_pass
        for (genvar n = 0; n < OW; n++) begin : g_out
            assign data_o[n*DATA_WIDTH +: DATA_WIDTH] = elem[n];
        end
    end
endmodule

// File: tb/tb_feature_row_streamer.sv
// Directed bench for feature_row_streamer: three instances (raw, ReLU, pool)
// share one stimulus; expected beats come from a small pattern model.
module tb_feature_row_streamer;
    localparam int H = 24, K = 8, DW = 8;
    localparam int FW = H * K * DW, RW = H * DW, PW = (H / 2) * DW;

    logic          clk = 1'b0, rst_n = 1'b1, done_i = 1'b0, ready_i = 1'b0;
    logic [FW-1:0] feat_i = '0;
    logic [RW-1:0] data0, data1;
    logic [PW-1:0] data2;
    logic [3:0]    ch    [3];
    logic [1:0]    st    [3];
    logic          valid [3], last [3], busy [3], done [3], ovr [3];

    int n_checks = 0, n_errors = 0;
    int beats, exp_ch;
    bit seen;

    typedef struct {
        logic [7:0] a, b, ra, rb, p;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    feature_row_streamer #(.H(H), .K(K), .DATA_WIDTH(DW), .RELU(0), .POOL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .feat_i(feat_i), .done_i(done_i), .data_o(data0),
        .ch_o(ch[0]), .valid_o(valid[0]), .ready_i(ready_i), .last_o(last[0]),
        .busy_o(busy[0]), .done_o(done[0]), .overrun_o(ovr[0]), .state_o(st[0]));
    feature_row_streamer #(.H(H), .K(K), .DATA_WIDTH(DW), .RELU(1), .POOL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .feat_i(feat_i), .done_i(done_i), .data_o(data1),
        .ch_o(ch[1]), .valid_o(valid[1]), .ready_i(ready_i), .last_o(last[1]),
        .busy_o(busy[1]), .done_o(done[1]), .overrun_o(ovr[1]), .state_o(st[1]));
    feature_row_streamer #(.H(H), .K(K), .DATA_WIDTH(DW), .RELU(0), .POOL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .feat_i(feat_i), .done_i(done_i), .data_o(data2),
        .ch_o(ch[2]), .valid_o(valid[2]), .ready_i(ready_i), .last_o(last[2]),
        .busy_o(busy[2]), .done_o(done[2]), .overrun_o(ovr[2]), .state_o(st[2]));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int sel, input int m, input int n);
        if (sel == 0) return 8'((m * H + n) % 128);
        return 8'((m * H + 3 * n + 100) % 256);
    endfunction

    function automatic logic [FW-1:0] mk_feat(input int sel);
        logic [FW-1:0] f;
        for (int m = 0; m < K; m++)
            for (int n = 0; n < H; n++) f[(m*H+n)*DW +: DW] = pat(sel, m, n);
        return f;
    endfunction

    function automatic logic [RW-1:0] exp_row(input int sel, input int m);
        logic [RW-1:0] r;
        for (int n = 0; n < H; n++) r[n*DW +: DW] = pat(sel, m, n);
        return r;
    endfunction

    // Leaves the bench at edge+2 with the first beat (ch 0) presented.
    task automatic start(input int sel);
        feat_i = mk_feat(sel);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f;
        logic [RW-1:0] er, eu;
        logic [PW-1:0] ep;

        vt[0] = '{8'h80, 8'h7f, 8'h00, 8'h7f, 8'h7f};
        vt[1] = '{8'hff, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2] = '{8'h01, 8'hff, 8'h01, 8'h00, 8'h01};
        vt[3] = '{8'hfb, 8'h03, 8'h00, 8'h03, 8'h03};
        vt[4] = '{8'h80, 8'h81, 8'h00, 8'h00, 8'h81};
        vt[5] = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
        vt[6] = '{8'h7f, 8'h80, 8'h7f, 8'h00, 8'h7f};
        vt[7] = '{8'hfe, 8'hfd, 8'h00, 8'h00, 8'hfe};

        // Reset state
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", valid[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_last", last[0], 0);
        chk("rst_ovr", ovr[0], 0);
        chk("rst_ch", ch[0], 0);
        chk("rst_state", st[0], 0);
        chk("rst_data0", data0, 0);
        chk("rst_data2", data2, 0);

        // Basic frame, ready held high
        feat_i  = mk_feat(0);
        done_i  = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("t1_valid_latency", valid[0], 0);
        step();
        done_i = 1'b0;
        #1;
        for (int m = 0; m < K; m++) begin
            chk("t1_valid", valid[0], 1);
            chk("t1_busy", busy[0], 1);
            chk("t1_ch", ch[0], m);
            chk("t1_data", data0, exp_row(0, m));
            chk("t1_last", last[0], (m == K - 1));
            if (m == 3) chk("t1_b3p5", data0[5*DW +: DW], 77);
            step();
            #1;
        end
        chk("t1_done", done[0], 1);
        chk("t1_done_valid", valid[0], 0);
        chk("t1_done_busy", busy[0], 1);
        step();
        #1;
        chk("t1_idle_done", done[0], 0);
        chk("t1_idle_busy", busy[0], 0);
        chk("t1_idle_state", st[0], 0);

        // Backpressure: stall on ch 2, then alternate ready
        start(0);
        step(); step();
        ready_i = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", valid[0], 1);
            chk("t2_stall_ch", ch[0], 2);
            chk("t2_stall_data", data0, exp_row(0, 2));
            step();
            #1;
        end
        beats = 2;
        exp_ch = 2;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            ready_i = (i % 2 == 0);
            #1;
            if (done[0]) seen = 1'b1;
            else begin
                chk("t2_valid", valid[0], 1);
                chk("t2_ch", ch[0], exp_ch);
                chk("t2_data", data0, exp_row(0, exp_ch));
                if (ready_i) begin
                    beats++;
                    exp_ch++;
                end
                step();
            end
        end
        chk("t2_done_seen", seen, 1);
        chk("t2_beats", beats, 8);
        ready_i = 1'b1;
        step();
        #1;

        // Overrun in ch 4, then back-to-back frame in the DONE cycle
        start(0);
        repeat (4) step();
        feat_i = mk_feat(1);
        done_i = 1'b1;
        #1;
        chk("t3_ovr_pulse", ovr[0], 1);
        chk("t3_ovr_ch", ch[0], 4);
        chk("t3_ovr_data", data0, exp_row(0, 4));
        step();
        done_i = 1'b0;
        #1;
        chk("t3_ovr_clear", ovr[0], 0);
        for (int m = 5; m < K; m++) begin
            chk("t3_a_ch", ch[0], m);
            chk("t3_a_data", data0, exp_row(0, m));
            step();
            #1;
        end
        chk("t3_done", done[0], 1);
        done_i = 1'b1;
        #1;
        chk("t3_done_no_ovr", ovr[0], 0);
        step();
        done_i = 1'b0;
        #1;
        chk("t3_b_valid", valid[0], 1);
        chk("t3_b_ch", ch[0], 0);
        chk("t3_b_data", data0, exp_row(1, 0));
        for (int m = 1; m < K; m++) begin
            step();
            #1;
            chk("t3_b_ch", ch[0], m);
            chk("t3_b_data", data0, exp_row(1, m));
        end
        step();
        #1;
        chk("t3_b_done", done[0], 1);
        step();
        #1;

        // Reset during ch 5
        start(0);
        repeat (5) step();
        rst_n = 1'b1;
        #1;
        chk("t4_pre_ch", ch[0], 5);
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_valid", valid[0], 0);
        chk("t4_busy", busy[0], 0);
        chk("t4_done", done[0], 0);
        chk("t4_last", last[0], 0);
        chk("t4_ch", ch[0], 0);
        chk("t4_data", data0, 0);
        chk("t4_state", st[0], 0);
        step();
        #1;
        chk("t4_no_done", done[0], 0);
        start(1);
        chk("t4_restart_valid", valid[0], 1);
        for (int m = 0; m < K; m++) begin
            chk("t4_restart_ch", ch[0], m);
            chk("t4_restart_data", data0, exp_row(1, m));
            step();
            #1;
        end
        chk("t4_restart_done", done[0], 1);
        step();
        #1;

        // Element path table: raw, ReLU and pool instances on paired patterns
        for (int v = 0; v < 8; v++) begin
            for (int n = 0; n < H * K; n++) f[n*DW +: DW] = (n % 2 == 0) ? vt[v].a : vt[v].b;
            for (int n = 0; n < H; n++) begin
                eu[n*DW +: DW] = (n % 2 == 0) ? vt[v].a : vt[v].b;
                er[n*DW +: DW] = (n % 2 == 0) ? vt[v].ra : vt[v].rb;
            end
            for (int n = 0; n < H / 2; n++) ep[n*DW +: DW] = vt[v].p;
            feat_i = f;
            done_i = 1'b1;
            step();
            done_i = 1'b0;
            #1;
            chk("t5_raw", data0, eu);
            chk("t5_relu", data1, er);
            chk("t5_pool", data2, ep);
            repeat (9) step();
            #1;
            chk("t5_idle", busy[0], 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
